transducer_burst_array: RTL and testbench
=========================================

Name: transducer_burst_array

Overview:
- Multi-channel successor to the single-channel transducer firing block.
- Drives NCH transducer outputs from one arm/fire handshake. Each channel has its own phase delay, charge time and mask, plus a shared burst count and pulse period.
- Each channel has a consecutive-high watchdog. A watchdog trip latches a fault that shuts down the whole array until reset.
- Sits between the sequencer (arm/fire/config) and the pulser drivers.

Parameters:
- NCH, 8, number of transducer channels
- PD_W, 16, width of phase delay and pulse period
- CT_W, 9, width of charge time
- NP_W, 4, width of burst pulse count
- WD_W, 10, watchdog width; trip limit L = 2^(WD_W-1) consecutive high cycles

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- arm  in  1  latch configuration and enter ARMED
- fire  in  1  start burst, sampled only in ARMED
- mask  in  NCH  per-channel output inhibit, latched at arm
- phase_delay  in  NCH*PD_W  channel i at [i*PD_W +: PD_W]
- charge_time  in  NCH*CT_W  channel i at [i*CT_W +: CT_W]
- pulse_count  in  NP_W  pulses per burst
- pulse_period  in  PD_W  rise-to-rise spacing within a burst
- tx_out  out  NCH  registered transducer drive
- fire_complete  out  1  high when idle or done
- busy  out  1  high in FIRING
- warning  out  1  latched watchdog fault
- warn_ch  out  NCH  channels that tripped the watchdog

Behaviour:
- Reset values: tx_out=0, fire_complete=1, busy=0, warning=0, warn_ch=0, state=IDLE, all counters 0.
- rst has priority in every state. Reset mid-burst drops tx_out at the same edge.
- States: IDLE, ARMED, FIRING, DONE, FAULT.
- IDLE or DONE, arm=1:
  - latch mask, phase_delay, charge_time, pulse_count and pulse_period; go to ARMED; fire_complete→0.
  - fire in the same cycle is ignored.
- ARMED:
  - arm=1 re-latches the configuration.
  - fire=1 (the sampling edge is E0) → FIRING; busy=1 from E0.
  - If arm and fire are both high, re-latch and fire. The newly latched values are used.
- Pulse timing (N_eff = max(pulse_count,1); P_eff = max(pulse_period, ct+1)):
  - Channel i with delay d rises at edge E(d+1).
  - Each pulse is high for exactly ct cycles.
  - Later pulses rise every P_eff cycles after the previous rise.
  - Total pulses = N_eff.
- ct=0: the channel never goes high and is done at E(d+1).
- Masked channel: tx_out[i] stays 0, but its counters run identically, so it completes at the same edge as if unmasked.
- Channel done is the edge at which its last pulse falls.
- FIRING→DONE at the edge the last channel completes. At that edge busy→0 and fire_complete→1; the last falling tx_out edge coincides.
- arm and fire are ignored during FIRING.
- Watchdog:
  - Per-channel counter increments each cycle tx_out[i]=1 and clears when tx_out[i]=0.
  - On reaching L, the next edge enters FAULT: all tx_out→0, warning=1, warn_ch[i]=1, fire_complete=0, busy=0.
  - Multiple channels tripping on the same edge each set their warn_ch bit.
- FAULT is exited only by rst. arm and fire are ignored in FAULT.
- Counter arithmetic:
  - All counters are unsigned and saturate at 0; no wrap-around.
  - The period counter is PD_W+1 bits so that ct+1 cannot overflow.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
1. NCH=8 defaults. arm with pd=[0,1,2,3,4,5,6,7], ct=3, N=1; fire at E0 -> ch0 high E1–E3, ch7 high E8–E10; fire_complete rises and busy falls at E11.
2. Burst: ch0 pd=2, ct=4, N=3, P=10 -> rises at E3, E13, E23, each 4 cycles high; done at E27. Repeat with P=2 -> P_eff=5, rises at E3, E8, E13.
3. mask=0x01, ct=5, pd=0, other channels ct=0 -> tx_out[0] never asserts; fire_complete at E6, identical to the unmasked run.
4. WD_W=4 (L=8), ch2 ct=20, ch5 ct=20, both pd=0 -> FAULT entered at E9 with all tx_out=0, warning=1, warn_ch=0x24; fire and arm ignored until rst clears everything.
5. rst asserted at E5 of a burst with tx_out=0xFF -> next edge tx_out=0, fire_complete=1, state IDLE; a following arm/fire works normally.
6. Handshake: fire without arm in IDLE -> no activity; arm and fire in the same IDLE cycle -> ARMED only. Then arm and fire together in ARMED with new pd -> the new pd is used. A second arm during FIRING -> ignored.

Source files
------------

// File: rtl/transducer_burst_array.sv
// Multi-channel transducer burst generator: one arm/fire handshake drives NCH phased pulse trains,
// with a per-channel consecutive-high watchdog that latches an array-wide fault.
module transducer_burst_array #(
    parameter int NCH  = 8,
    parameter int PD_W = 16,
    parameter int CT_W = 9,
    parameter int NP_W = 4,
    parameter int WD_W = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arm,
    input  logic                 fire,
    input  logic [NCH-1:0]       mask,
    input  logic [NCH*PD_W-1:0]  phase_delay,
    input  logic [NCH*CT_W-1:0]  charge_time,
    input  logic [NP_W-1:0]      pulse_count,
    input  logic [PD_W-1:0]      pulse_period,
    output logic [NCH-1:0]       tx_out,
    output logic                 fire_complete,
    output logic                 busy,
    output logic                 warning,
    output logic [NCH-1:0]       warn_ch
);

    typedef enum logic [2:0] {IDLE, ARMED, FIRING, DONE, FAULT} state_t;

    localparam int PW = PD_W + 1;
    localparam logic [WD_W-1:0] LIMIT = {1'b1, {(WD_W-1){1'b0}}};

    state_t state, next_state;

    logic [NCH-1:0]  mask_q;
    logic [PD_W-1:0] pd_q [NCH];
    logic [CT_W-1:0] ct_q [NCH];
    logic [NP_W-1:0] pc_q;
    logic [PD_W-1:0] pp_q;

    logic [PD_W-1:0] dly_q  [NCH], dly_n  [NCH];
    logic [CT_W-1:0] hi_q   [NCH], hi_n   [NCH];
    logic [PW-1:0]   per_q  [NCH], per_n  [NCH];
    logic [NP_W-1:0] left_q [NCH], left_n [NCH];
    logic [NCH-1:0]  started_q, started_n, done_q, done_n, tx_raw_q, tx_raw_n;
    logic [WD_W-1:0] wd_q   [NCH];

    logic [PW-1:0]   ct_plus1 [NCH];
    logic [PW-1:0]   p_eff    [NCH];
    logic [NP_W-1:0] n_eff_load;
    logic [NCH-1:0]  trip_bits, tx_next;
    logic            load, latch, trip, all_done_n;

    assign load       = (state == ARMED) && fire;
    assign latch      = arm && (state == IDLE || state == DONE || state == ARMED);
    assign n_eff_load = arm ? ((pulse_count == '0) ? NP_W'(1) : pulse_count)
                            : ((pc_q == '0) ? NP_W'(1) : pc_q);

    // Period is widened by one bit so ct+1 never overflows when it dominates.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ct_plus1[i]  = PW'(ct_q[i]) + PW'(1);
            p_eff[i]     = (PW'(pp_q) > ct_plus1[i]) ? PW'(pp_q) : ct_plus1[i];
            trip_bits[i] = (wd_q[i] == LIMIT);
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            dly_n[i]     = dly_q[i];
            hi_n[i]      = hi_q[i];
            per_n[i]     = per_q[i];
            left_n[i]    = left_q[i];
            started_n[i] = started_q[i];
            done_n[i]    = done_q[i];
            tx_raw_n[i]  = tx_raw_q[i];
            if (load) begin
                dly_n[i]     = arm ? phase_delay[i*PD_W +: PD_W] : pd_q[i];
                left_n[i]    = n_eff_load;
                hi_n[i]      = '0;
                per_n[i]     = '0;
                started_n[i] = 1'b0;
                done_n[i]    = 1'b0;
                tx_raw_n[i]  = 1'b0;
            end else if (state == FIRING && !done_q[i]) begin
                if (!started_q[i]) begin
                    if (dly_q[i] == '0) begin
                        started_n[i] = 1'b1;
                        if (ct_q[i] == '0) begin
                            done_n[i] = 1'b1;
                        end else begin
                            tx_raw_n[i] = 1'b1;
                            hi_n[i]     = ct_q[i] - CT_W'(1);
                            per_n[i]    = p_eff[i] - PW'(1);
                            left_n[i]   = left_q[i] - NP_W'(1);
                        end
                    end else begin
                        dly_n[i] = dly_q[i] - PD_W'(1);
                    end
                end else if (tx_raw_q[i]) begin
                    if (hi_q[i] == '0) begin
                        tx_raw_n[i] = 1'b0;
                        if (left_q[i] == '0) done_n[i] = 1'b1;
                    end else begin
                        hi_n[i] = hi_q[i] - CT_W'(1);
                    end
                    if (per_q[i] != '0) per_n[i] = per_q[i] - PW'(1);
                end else begin
                    if (per_q[i] != '0) begin
                        per_n[i] = per_q[i] - PW'(1);
                    end else if (left_q[i] != '0) begin
                        tx_raw_n[i] = 1'b1;
                        hi_n[i]     = ct_q[i] - CT_W'(1);
                        per_n[i]    = p_eff[i] - PW'(1);
                        left_n[i]   = left_q[i] - NP_W'(1);
                    end
                end
            end else if (state != FIRING) begin
                tx_raw_n[i] = 1'b0;
            end
        end
    end

    assign all_done_n = &done_n;
    assign trip       = (state == FIRING) && (|trip_bits);

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE, DONE: if (arm) next_state = ARMED;
            ARMED:      if (fire) next_state = FIRING;
            FIRING: begin
                if (trip)            next_state = FAULT;
                else if (all_done_n) next_state = DONE;
            end
            FAULT:      next_state = FAULT;
            default:    next_state = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state == FIRING);
        fire_complete = (state == IDLE) || (state == DONE);
        warning       = (state == FAULT);
    end

    assign tx_next = (next_state == FIRING) ? (tx_raw_n & ~mask_q) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mask_q    <= '0;
            pc_q      <= '0;
            pp_q      <= '0;
            started_q <= '0;
            done_q    <= '0;
            tx_raw_q  <= '0;
            tx_out    <= '0;
            warn_ch   <= '0;
            for (int i = 0; i < NCH; i++) begin
                pd_q[i]   <= '0;
                ct_q[i]   <= '0;
                dly_q[i]  <= '0;
                hi_q[i]   <= '0;
                per_q[i]  <= '0;
                left_q[i] <= '0;
                wd_q[i]   <= '0;
            end
        end else begin
            state     <= next_state;
            started_q <= started_n;
            done_q    <= done_n;
            tx_raw_q  <= tx_raw_n;
            tx_out    <= tx_next;
            if (latch) begin
                mask_q <= mask;
                pc_q   <= pulse_count;
                pp_q   <= pulse_period;
            end
            if (trip) warn_ch <= trip_bits;
            // Watchdog follows the driven output and saturates at the trip limit.
            for (int i = 0; i < NCH; i++) begin
                if (latch) begin
                    pd_q[i] <= phase_delay[i*PD_W +: PD_W];
                    ct_q[i] <= charge_time[i*CT_W +: CT_W];
                end
                dly_q[i]  <= dly_n[i];
                hi_q[i]   <= hi_n[i];
                per_q[i]  <= per_n[i];
                left_q[i] <= left_n[i];
                if (!tx_next[i])           wd_q[i] <= '0;
                else if (wd_q[i] != LIMIT) wd_q[i] <= wd_q[i] + WD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_transducer_burst_array.sv
// Scoreboard bench for transducer_burst_array: stimulus pushes hand-derived per-cycle
// expectations, a monitor pops and compares them on the falling edge.
module tb_transducer_burst_array;

    localparam int NCH  = 8;
    localparam int PD_W = 16;
    localparam int CT_W = 9;
    localparam int NP_W = 4;
    localparam int WD_W = 4;

    logic                clk = 1'b0;
    logic                rst, arm, fire;
    logic [NCH-1:0]      mask;
    logic [NCH*PD_W-1:0] phase_delay;
    logic [NCH*CT_W-1:0] charge_time;
    logic [NP_W-1:0]     pulse_count;
    logic [PD_W-1:0]     pulse_period;
    logic [NCH-1:0]      tx_out;
    logic                fire_complete, busy, warning;
    logic [NCH-1:0]      warn_ch;

    logic [PD_W-1:0] pd [NCH];
    logic [CT_W-1:0] ct [NCH];

    typedef struct {
        string      name;
        logic [7:0] tx;
        logic       busy;
        logic       fc;
        logic       warn;
        logic [7:0] wch;
    } exp_t;

    exp_t  sb[$];
    int    total_cnt = 0;
    int    pass_cnt  = 0;
    string cur_name  = "reset";

    int         exp_first [NCH];
    int         exp_ct    [NCH];
    int         exp_p     [NCH];
    int         exp_n;
    logic [7:0] exp_mask;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            phase_delay[i*PD_W +: PD_W] = pd[i];
            charge_time[i*CT_W +: CT_W] = ct[i];
        end
    end

    transducer_burst_array #(
        .NCH(NCH), .PD_W(PD_W), .CT_W(CT_W), .NP_W(NP_W), .WD_W(WD_W)
    ) dut (
        .clk(clk), .rst(rst), .arm(arm), .fire(fire), .mask(mask),
        .phase_delay(phase_delay), .charge_time(charge_time),
        .pulse_count(pulse_count), .pulse_period(pulse_period),
        .tx_out(tx_out), .fire_complete(fire_complete), .busy(busy),
        .warning(warning), .warn_ch(warn_ch)
    );

    function automatic exp_t mk(input logic [7:0] tx, input logic b, input logic fc,
                                input logic w, input logic [7:0] wch);
        exp_t e;
        e.name = cur_name; e.tx = tx; e.busy = b; e.fc = fc; e.warn = w; e.wch = wch;
        return e;
    endfunction

    function automatic logic pulse_hi(input int k, input int first, input int ctv,
                                      input int n, input int p);
        for (int j = 0; j < n; j++) begin
            if (k >= first + j*p && k < first + j*p + ctv) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic checkOutput(input exp_t e);
        total_cnt++;
        if (tx_out === e.tx && busy === e.busy && fire_complete === e.fc &&
            warning === e.warn && warn_ch === e.wch) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got tx=%h busy=%b fc=%b warn=%b wch=%h, want tx=%h busy=%b fc=%b warn=%b wch=%h",
                     e.name, tx_out, busy, fire_complete, warning, warn_ch,
                     e.tx, e.busy, e.fc, e.warn, e.wch);
        end
    endtask

    // Monitor: one expectation per clock, compared half a cycle after its edge.
    initial forever begin
        @(negedge clk);
        if (sb.size() > 0) checkOutput(sb.pop_front());
    end

    task automatic applyStimulus(input logic a, input logic f, input logic r, input exp_t e);
        @(negedge clk);
        arm = a; fire = f; rst = r;
        @(posedge clk);
        #1;
        sb.push_back(e);
    endtask

    task automatic startBurst();
        applyStimulus(1'b1, 1'b0, 1'b0, mk(8'h00, 1'b0, 1'b0, 1'b0, 8'h00));
        applyStimulus(1'b0, 1'b1, 1'b0, mk(8'h00, 1'b1, 1'b0, 1'b0, 8'h00));
    endtask

    task automatic runFiring(input int ncyc, input int done_e, input int arm_at);
        logic [7:0] tx;
        for (int k = 1; k <= ncyc; k++) begin
            for (int i = 0; i < NCH; i++)
                tx[i] = !exp_mask[i] && pulse_hi(k, exp_first[i], exp_ct[i], exp_n, exp_p[i]);
            applyStimulus(k == arm_at, k == arm_at, 1'b0,
                          mk(tx, k < done_e, k >= done_e, 1'b0, 8'h00));
        end
    endtask

    task automatic clearConfig();
        for (int i = 0; i < NCH; i++) begin
            pd[i] = '0; ct[i] = '0;
            exp_first[i] = 1; exp_ct[i] = 0; exp_p[i] = 1;
        end
        mask = '0; exp_mask = '0; pulse_count = 4'd1; pulse_period = '0; exp_n = 1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, got no end, want end");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1; arm = 1'b0; fire = 1'b0;
        clearConfig();

        cur_name = "reset";
        applyStimulus(1'b0, 1'b0, 1'b1, mk(8'h00, 1'b0, 1'b1, 1'b0, 8'h00));
        applyStimulus(1'b0, 1'b0, 1'b0, mk(8'h00, 1'b0, 1'b1, 1'b0, 8'h00));

        cur_name = "t1_stagger";
        clearConfig();
        for (int i = 0; i < NCH; i++) begin
            pd[i] = PD_W'(i); ct[i] = 9'd3;
            exp_first[i] = i + 1; exp_ct[i] = 3; exp_p[i] = 4;
        end
        startBurst();
        runFiring(13, 11, 0);

        cur_name = "t2_burst_p10";
        clearConfig();
        pd[0] = 16'd2; ct[0] = 9'd4; pulse_count = 4'd3; pulse_period = 16'd10;
        exp_first[0] = 3; exp_ct[0] = 4; exp_p[0] = 10; exp_n = 3;
        startBurst();
        runFiring(29, 27, 0);

        cur_name = "t2_burst_p2";
        pulse_period = 16'd2; exp_p[0] = 5;
        startBurst();
        runFiring(19, 17, 0);

        cur_name = "t3_masked";
        clearConfig();
        ct[0] = 9'd5; exp_ct[0] = 5; mask = 8'h01; exp_mask = 8'h01;
        startBurst();
        runFiring(8, 6, 0);

        cur_name = "t3_unmasked";
        mask = 8'h00; exp_mask = 8'h00;
        startBurst();
        runFiring(8, 6, 0);

        cur_name = "t4_watchdog";
        clearConfig();
        ct[2] = 9'd20; ct[5] = 9'd20;
        startBurst();
        for (int k = 1; k <= 8; k++)
            applyStimulus(1'b0, 1'b0, 1'b0, mk(8'h24, 1'b1, 1'b0, 1'b0, 8'h00));
        applyStimulus(1'b0, 1'b0, 1'b0, mk(8'h00, 1'b0, 1'b0, 1'b1, 8'h24));
        cur_name = "t4_fault_hold";
        ct[2] = 9'd1; ct[5] = 9'd1;
        applyStimulus(1'b1, 1'b1, 1'b0, mk(8'h00, 1'b0, 1'b0, 1'b1, 8'h24));
        applyStimulus(1'b0, 1'b1, 1'b0, mk(8'h00, 1'b0, 1'b0, 1'b1, 8'h24));
        applyStimulus(1'b1, 1'b0, 1'b0, mk(8'h00, 1'b0, 1'b0, 1'b1, 8'h24));
        cur_name = "t4_fault_reset";
        applyStimulus(1'b0, 1'b0, 1'b1, mk(8'h00, 1'b0, 1'b1, 1'b0, 8'h00));

        cur_name = "t5_reset_mid";
        clearConfig();
        for (int i = 0; i < NCH; i++) ct[i] = 9'd10;
        startBurst();
        for (int k = 1; k <= 4; k++)
            applyStimulus(1'b0, 1'b0, 1'b0, mk(8'hFF, 1'b1, 1'b0, 1'b0, 8'h00));
        applyStimulus(1'b0, 1'b0, 1'b1, mk(8'h00, 1'b0, 1'b1, 1'b0, 8'h00));
        cur_name = "t5_after_reset";
        for (int i = 0; i < NCH; i++) begin
            ct[i] = 9'd2; exp_ct[i] = 2; exp_p[i] = 3;
        end
        startBurst();
        runFiring(4, 3, 0);

        cur_name = "t6_fire_no_arm";
        applyStimulus(1'b0, 1'b0, 1'b1, mk(8'h00, 1'b0, 1'b1, 1'b0, 8'h00));
        clearConfig();
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b0, 1'b1, 1'b0, mk(8'h00, 1'b0, 1'b1, 1'b0, 8'h00));
        cur_name = "t6_arm_fire_idle";
        ct[0] = 9'd2;
        applyStimulus(1'b1, 1'b1, 1'b0, mk(8'h00, 1'b0, 1'b0, 1'b0, 8'h00));
        applyStimulus(1'b0, 1'b0, 1'b0, mk(8'h00, 1'b0, 1'b0, 1'b0, 8'h00));
        cur_name = "t6_rearm_fire";
        pd[0] = 16'd3;
        applyStimulus(1'b1, 1'b1, 1'b0, mk(8'h00, 1'b1, 1'b0, 1'b0, 8'h00));
        exp_first[0] = 4; exp_ct[0] = 2; exp_p[0] = 3;
        pd[0] = 16'd0; ct[0] = 9'd7;
        runFiring(8, 6, 2);
        cur_name = "t6_fire_in_done";
        applyStimulus(1'b0, 1'b1, 1'b0, mk(8'h00, 1'b0, 1'b1, 1'b0, 8'h00));

        for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
        @(negedge clk);
        if (sb.size() > 0) begin
            total_cnt++;
            $display("[TB] FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
